multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: instruction width; the opcode is always bits [6:0].
REQ-002 SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port instr, input, XLEN bits: instruction register contents, valid from DECODE onward.
REQ-006 SHALL have port eq, input, 1 bit: ALU zero/equal flag.
REQ-007 SHALL have port mem_ready, input, 1 bit: memory completes the current request this cycle.
REQ-008 SHALL have outputs mem_req (1), mem_we (1), adrsrc (1; 0=PC, 1=ALU result), ir_we (1), pc_we (1) and regwrite (1).
REQ-009 SHALL have outputs alusrc_a (2; 0=PC, 1=oldPC, 2=RD1), alusrc_b (2; 0=RD2, 1=imm, 2=const 4), aluctrl (3), immsrc (3) and resultsrc (2; 0=ALUout, 1=memdata, 2=ALU result).
REQ-010 SHALL have outputs illegal (1, sticky trap flag) and retired (CNT_W bits).

Function
REQ-011 SHALL implement a Moore FSM with states FETCH, DECODE, EXEC_R, EXEC_I, MEMADR, MEMRD, MEMWB, MEMWR, ALUWB, BRANCH, JAL and TRAP.
REQ-012 SHALL, in FETCH, drive mem_req=1, adrsrc=0, alusrc_a=0, alusrc_b=2 and aluctrl=add.
REQ-013 SHALL hold FETCH while mem_ready=0.
REQ-014 SHALL, when FETCH sees mem_ready=1, pulse ir_we=1 and pc_we=1 in that cycle and go to DECODE.
REQ-015 SHALL, in DECODE, compute oldPC+imm (alusrc_a=1, alusrc_b=1, immsrc=B-type) and branch on opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEMADR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other opcode -> TRAP
REQ-016 SHALL decode aluctrl from funct3/funct7[5] as: add 000, sub 001, and 010, or 011, slt 101.
  - R-type funct7[5]=1 with funct3=000 -> sub.
  - Unsupported funct3 -> TRAP.
REQ-017 SHALL set immsrc as: I 000, S 001, B 010, J 011.
REQ-018 SHALL go from EXEC_R and EXEC_I to ALUWB.
  - EXEC_R uses alusrc_a=2, alusrc_b=0.
  - EXEC_I uses alusrc_a=2, alusrc_b=1.
REQ-019 SHALL, in ALUWB, assert regwrite=1 with resultsrc=0, then go to FETCH.
REQ-020 SHALL, in MEMADR, compute RD1+imm, then go to MEMRD for loads or MEMWR for stores.
REQ-021 SHALL, in MEMRD and MEMWR, assert mem_req=1 and adrsrc=1, with mem_we=1 only in MEMWR.
REQ-022 SHALL hold MEMRD and MEMWR until mem_ready=1.
  - MEMRD then goes to MEMWB.
  - MEMWR then goes to FETCH.
REQ-023 SHALL, in MEMWB, assert regwrite=1 with resultsrc=1, then go to FETCH.
REQ-024 SHALL, in BRANCH, compute RD1-RD2 (aluctrl=sub) and decide the branch from funct3:
  - funct3=000 (beq): taken iff eq=1.
  - funct3=001 (bne): taken iff eq=0.
  - Taken: pc_we=1, resultsrc=0 (target from ALUout).
  - Any other funct3 -> TRAP.
  - Otherwise -> FETCH.
REQ-025 SHALL, in JAL, write the link address and load the target in one cycle, then go to FETCH:
  - regwrite=1 with oldPC+4 (alusrc_a=1, alusrc_b=2, resultsrc=2).
  - pc_we=1 loading the target from ALUout.
REQ-026 SHALL, in TRAP, hold illegal=1 with all write enables and mem_req at 0, and never leave TRAP except by reset.
REQ-027 SHALL increment retired by 1 on the final cycle of every completed instruction: ALUWB, MEMWB, MEMWR with mem_ready=1, BRANCH, JAL.
REQ-028 SHALL wrap retired from 2^CNT_W-1 to 0 without a flag.
REQ-029 SHALL drive every output not listed for a state to 0.
REQ-030 SHALL never assert mem_req, regwrite and pc_we together in one cycle.

Reset
REQ-031 SHALL, while rst=1, force the state to FETCH, retired=0 and illegal=0 immediately, independent of clk.
REQ-032 SHALL drive all outputs to their REQ-029 defaults during reset except FETCH's combinational ALU selects.
REQ-033 SHALL suppress pc_we, ir_we, regwrite and mem_we while rst=1.
REQ-034 SHALL, after rst deasserts mid-instruction, restart at FETCH with no partial write.

Verification
REQ-035 SHALL verify fetch stall: mem_ready low 3 cycles then high -> mem_req high 4 cycles, ir_we/pc_we single pulse on the 4th, DECODE next.
REQ-036 SHALL verify add (0x002081B3), mem_ready always 1 -> FETCH, DECODE, EXEC_R, ALUWB; regwrite in cycle 4; retired 0->1.
REQ-037 SHALL verify lw (0x0040A183) with 2-cycle MEMRD wait -> MEMWB regwrite with resultsrc=1; total 7 cycles; retired+1.
REQ-038 SHALL verify beq (0x00208463) eq=1 -> pc_we in BRANCH; eq=0 -> no pc_we; bne inverse.
REQ-039 SHALL verify opcode 0x7F -> TRAP after DECODE; illegal=1 held 100 cycles; async rst clears to FETCH.
REQ-040 SHALL verify counter wrap with CNT_W=4: 17 adds -> retired=1.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Bundle of signals between the multicycle control unit and its datapath.
// The master side is the datapath (it supplies the instruction, the flags and
// the memory handshake); the slave side is the control unit.
interface multicycle_control_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [XLEN-1:0]  instr;
  logic             eq;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             adrsrc;
  logic             ir_we;
  logic             pc_we;
  logic             regwrite;
  logic [1:0]       alusrc_a;
  logic [1:0]       alusrc_b;
  logic [2:0]       aluctrl;
  logic [2:0]       immsrc;
  logic [1:0]       resultsrc;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    output instr, eq, mem_ready,
    input  mem_req, mem_we, adrsrc, ir_we, pc_we, regwrite,
    input  alusrc_a, alusrc_b, aluctrl, immsrc, resultsrc, illegal, retired
  );

  modport slave (
    input  instr, eq, mem_ready,
    output mem_req, mem_we, adrsrc, ir_we, pc_we, regwrite,
    output alusrc_a, alusrc_b, aluctrl, immsrc, resultsrc, illegal, retired
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V style control unit: Moore FSM sequencing fetch, decode,
// execute, memory and writeback, plus a retired-instruction counter.
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4 into PC when memory answers
// DECODE | latch operands, oldPC+imm(B) into ALUout, dispatch on opcode
// EXEC_R | RD1 op RD2
// EXEC_I | RD1 op imm
// MEMADR | RD1+imm address calculation
// MEMRD  | load request, wait for mem_ready
// MEMWB  | write loaded data to register file
// MEMWR  | store request, wait for mem_ready
// ALUWB  | write ALUout to register file
// BRANCH | compare RD1-RD2, load branch target when taken
// JAL    | link oldPC+4, load jump target
// TRAP   | illegal instruction, left only by reset
module multicycle_control_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  multicycle_control_unit_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEMADR, S_MEMRD,
    S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [XLEN-1:0]  instr_w;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7_b5;
  logic             alu_ok;
  logic [2:0]       alu_dec;
  logic             br_taken;

  logic       mem_req_c, mem_we_c, adrsrc_c, ir_we_c, pc_we_c, regwrite_c;
  logic [1:0] alusrc_a_c, alusrc_b_c, resultsrc_c;
  logic [2:0] aluctrl_c, immsrc_c;

  assign instr_w   = bus.instr;
  assign opcode    = instr_w[6:0];
  assign funct3    = instr_w[14:12];
  assign funct7_b5 = instr_w[30];
  assign br_taken  = (funct3 == 3'b000) ? bus.eq : !bus.eq;

  // ALU operation for R/I arithmetic; funct7[5] only selects sub on R-type
  // because on I-type that bit belongs to the immediate.
  always_comb begin
    alu_ok  = 1'b1;
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (opcode == OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_dec = ALU_AND;
      3'b110:  alu_dec = ALU_OR;
      3'b010:  alu_dec = ALU_SLT;
      default: alu_ok  = 1'b0;
    endcase
  end

  // Next state, counter update and per-state control outputs.
  always_comb begin
    state_d     = state_q;
    retired_d   = retired_q;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    adrsrc_c    = 1'b0;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    regwrite_c  = 1'b0;
    alusrc_a_c  = 2'd0;
    alusrc_b_c  = 2'd0;
    resultsrc_c = 2'd0;
    aluctrl_c   = ALU_ADD;
    immsrc_c    = IMM_I;
    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        alusrc_b_c = 2'd2;
        ir_we_c    = bus.mem_ready;
        pc_we_c    = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrc_a_c = 2'd1;
        alusrc_b_c = 2'd1;
        immsrc_c   = IMM_B;
        case (opcode)
          OP_R:         state_d = alu_ok ? S_EXEC_R : S_TRAP;
          OP_I:         state_d = alu_ok ? S_EXEC_I : S_TRAP;
          OP_LD, OP_ST: state_d = S_MEMADR;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alusrc_a_c = 2'd2;
        aluctrl_c  = alu_dec;
        state_d    = S_ALUWB;
      end
      S_EXEC_I: begin
        alusrc_a_c = 2'd2;
        alusrc_b_c = 2'd1;
        aluctrl_c  = alu_dec;
        state_d    = S_ALUWB;
      end
      S_MEMADR: begin
        alusrc_a_c = 2'd2;
        alusrc_b_c = 2'd1;
        immsrc_c   = (opcode == OP_ST) ? IMM_S : IMM_I;
        state_d    = (opcode == OP_ST) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        adrsrc_c  = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        adrsrc_c  = 1'b1;
        if (bus.mem_ready) begin
          state_d   = S_FETCH;
          retired_d = retired_q + CNT_W'(1);
        end
      end
      S_MEMWB: begin
        regwrite_c  = 1'b1;
        resultsrc_c = 2'd1;
        state_d     = S_FETCH;
        retired_d   = retired_q + CNT_W'(1);
      end
      S_ALUWB: begin
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
        retired_d  = retired_q + CNT_W'(1);
      end
      S_BRANCH: begin
        alusrc_a_c = 2'd2;
        aluctrl_c  = ALU_SUB;
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          pc_we_c   = br_taken;
          state_d   = S_FETCH;
          retired_d = retired_q + CNT_W'(1);
        end else begin
          state_d = S_TRAP;
        end
      end
      S_JAL: begin
        regwrite_c  = 1'b1;
        pc_we_c     = 1'b1;
        alusrc_a_c  = 2'd1;
        alusrc_b_c  = 2'd2;
        resultsrc_c = 2'd2;
        state_d     = S_FETCH;
        retired_d   = retired_q + CNT_W'(1);
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // State and retired counter; reset forces FETCH without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Reset holds state in FETCH, so only the enables need masking; the ALU
  // selects keep FETCH's values.
  assign bus.mem_req   = mem_req_c & ~rst;
  assign bus.mem_we    = mem_we_c & ~rst;
  assign bus.ir_we     = ir_we_c & ~rst;
  assign bus.pc_we     = pc_we_c & ~rst;
  assign bus.regwrite  = regwrite_c & ~rst;
  assign bus.adrsrc    = adrsrc_c;
  assign bus.alusrc_a  = alusrc_a_c;
  assign bus.alusrc_b  = alusrc_b_c;
  assign bus.aluctrl   = aluctrl_c;
  assign bus.immsrc    = immsrc_c;
  assign bus.resultsrc = resultsrc_c;
  assign bus.illegal   = (state_q == S_TRAP);
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: table of single-instruction runs plus
// hand-written sequences for stalls, traps, reset and counter wrap.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   viol = 0;

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.XLEN(32), .CNT_W(16)) bus ();
  multicycle_control_unit_if #(.XLEN(32), .CNT_W(4))  bus2 ();

  multicycle_control_unit #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  multicycle_control_unit #(.XLEN(32), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2.slave)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic        eq;
    logic [3:0]  cycles;
    logic [2:0]  alu3;
    logic [2:0]  n_rw;
    logic [2:0]  n_pcwe;
    logic [2:0]  n_mreq;
    logic [2:0]  n_mwe;
    logic        d_ret;
    logic        trap;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  // Write enables must never line up with a memory request and a PC write.
  always @(negedge clk)
    if (bus.mem_req && bus.regwrite && bus.pc_we) viol++;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int rw, pcwe, mreq, mwe, r0, alu, bad;
    logic [0:6] rdy_seq, mreq_seq, adr_seq, rw_seq;

    //               instr         eq cyc alu   rw pc mr mw r  t
    vecs[0]  = '{32'h002081B3, 1'b0, 4'd4, 3'b000, 3'd1, 3'd1, 3'd1, 3'd0, 1'b1, 1'b0}; // add
    vecs[1]  = '{32'h402081B3, 1'b0, 4'd4, 3'b001, 3'd1, 3'd1, 3'd1, 3'd0, 1'b1, 1'b0}; // sub
    vecs[2]  = '{32'h0020F1B3, 1'b0, 4'd4, 3'b010, 3'd1, 3'd1, 3'd1, 3'd0, 1'b1, 1'b0}; // and
    vecs[3]  = '{32'h0020A1B3, 1'b0, 4'd4, 3'b101, 3'd1, 3'd1, 3'd1, 3'd0, 1'b1, 1'b0}; // slt
    vecs[4]  = '{32'hFFF00093, 1'b0, 4'd4, 3'b000, 3'd1, 3'd1, 3'd1, 3'd0, 1'b1, 1'b0}; // addi -1
    vecs[5]  = '{32'h0010E093, 1'b0, 4'd4, 3'b011, 3'd1, 3'd1, 3'd1, 3'd0, 1'b1, 1'b0}; // ori
    vecs[6]  = '{32'h0040A183, 1'b0, 4'd5, 3'b000, 3'd1, 3'd1, 3'd2, 3'd0, 1'b1, 1'b0}; // lw
    vecs[7]  = '{32'h0030A223, 1'b0, 4'd4, 3'b000, 3'd0, 3'd1, 3'd2, 3'd1, 1'b1, 1'b0}; // sw
    vecs[8]  = '{32'h00208463, 1'b1, 4'd3, 3'b001, 3'd0, 3'd2, 3'd1, 3'd0, 1'b1, 1'b0}; // beq taken
    vecs[9]  = '{32'h00208463, 1'b0, 4'd3, 3'b001, 3'd0, 3'd1, 3'd1, 3'd0, 1'b1, 1'b0}; // beq not
    vecs[10] = '{32'h00209463, 1'b0, 4'd3, 3'b001, 3'd0, 3'd2, 3'd1, 3'd0, 1'b1, 1'b0}; // bne taken
    vecs[11] = '{32'h00209463, 1'b1, 4'd3, 3'b001, 3'd0, 3'd1, 3'd1, 3'd0, 1'b1, 1'b0}; // bne not
    vecs[12] = '{32'h008000EF, 1'b0, 4'd3, 3'b000, 3'd1, 3'd2, 3'd1, 3'd0, 1'b1, 1'b0}; // jal
    vecs[13] = '{32'h0020C463, 1'b0, 4'd3, 3'b001, 3'd0, 3'd1, 3'd1, 3'd0, 1'b0, 1'b1}; // blt -> trap
    vecs[14] = '{32'h002091B3, 1'b0, 4'd2, 3'b000, 3'd0, 3'd1, 3'd1, 3'd0, 1'b0, 1'b1}; // sll -> trap
    vecs[15] = '{32'h00109093, 1'b0, 4'd2, 3'b000, 3'd0, 3'd1, 3'd1, 3'd0, 1'b0, 1'b1}; // slli -> trap
    vecs[16] = '{32'h0000007F, 1'b0, 4'd2, 3'b000, 3'd0, 3'd1, 3'd1, 3'd0, 1'b0, 1'b1}; // bad opcode

    bus.instr = 32'h0; bus.eq = 1'b0; bus.mem_ready = 1'b1;
    bus2.instr = 32'h002081B3; bus2.eq = 1'b0; bus2.mem_ready = 1'b1;

    // reset state
    #2;
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_retired", bus.retired, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_pc_we", bus.pc_we, 0);
    chk("rst_alusrc_b", bus.alusrc_b, 2);
    tick();
    rst = 1'b0;

    // table-driven single-instruction runs, memory always ready
    for (int i = 0; i < NV; i++) begin
      do_reset();
      bus.instr = vecs[i].instr;
      bus.eq = vecs[i].eq;
      bus.mem_ready = 1'b1;
      rw = 0; pcwe = 0; mreq = 0; mwe = 0; alu = 0; r0 = 0;
      for (int c = 0; c < int'(vecs[i].cycles); c++) begin
        @(negedge clk);
        if (c == 0) r0 = bus.retired;
        rw += bus.regwrite; pcwe += bus.pc_we; mreq += bus.mem_req; mwe += bus.mem_we;
        if (c == 2) alu = bus.aluctrl;
        tick();
      end
      @(negedge clk);
      chk($sformatf("v%0d_regwrite", i), rw, vecs[i].n_rw);
      chk($sformatf("v%0d_pc_we", i), pcwe, vecs[i].n_pcwe);
      chk($sformatf("v%0d_mem_req", i), mreq, vecs[i].n_mreq);
      chk($sformatf("v%0d_mem_we", i), mwe, vecs[i].n_mwe);
      if (vecs[i].cycles >= 4'd3) chk($sformatf("v%0d_aluctrl", i), alu, vecs[i].alu3);
      chk($sformatf("v%0d_retired", i), bus.retired - r0, vecs[i].d_ret);
      chk($sformatf("v%0d_illegal", i), bus.illegal, vecs[i].trap);
      chk($sformatf("v%0d_end_mem_req", i), bus.mem_req, vecs[i].trap ? 0 : 1);
    end

    // fetch stall: ready low 3 cycles then high
    do_reset();
    bus.instr = 32'h002081B3;
    bus.mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_mem_req", bus.mem_req, 1);
      chk("stall_ir_we", bus.ir_we, 0);
      chk("stall_pc_we", bus.pc_we, 0);
      tick();
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("stall4_mem_req", bus.mem_req, 1);
    chk("stall4_ir_we", bus.ir_we, 1);
    chk("stall4_pc_we", bus.pc_we, 1);
    tick();
    @(negedge clk);
    chk("decode_mem_req", bus.mem_req, 0);
    chk("decode_ir_we", bus.ir_we, 0);
    chk("decode_alusrc_a", bus.alusrc_a, 1);
    chk("decode_alusrc_b", bus.alusrc_b, 1);
    chk("decode_immsrc", bus.immsrc, 2);

    // add cycle by cycle
    do_reset();
    bus.instr = 32'h002081B3;
    bus.mem_ready = 1'b1;
    chk("add_ret_before", bus.retired, 0);
    @(negedge clk); chk("add_c1_mem_req", bus.mem_req, 1); tick();
    @(negedge clk); chk("add_c2_regwrite", bus.regwrite, 0); tick();
    @(negedge clk);
    chk("add_c3_alusrc_a", bus.alusrc_a, 2);
    chk("add_c3_alusrc_b", bus.alusrc_b, 0);
    chk("add_c3_regwrite", bus.regwrite, 0);
    tick();
    @(negedge clk);
    chk("add_c4_regwrite", bus.regwrite, 1);
    chk("add_c4_resultsrc", bus.resultsrc, 0);
    tick();
    chk("add_ret_after", bus.retired, 1);

    // lw with two wait cycles in MEMRD, continuing from the add
    rdy_seq  = 7'b1110011;
    mreq_seq = 7'b1001110;
    adr_seq  = 7'b0001110;
    rw_seq   = 7'b0000001;
    bus.instr = 32'h0040A183;
    for (int c = 0; c < 7; c++) begin
      bus.mem_ready = rdy_seq[c];
      @(negedge clk);
      chk($sformatf("lw_c%0d_mem_req", c + 1), bus.mem_req, mreq_seq[c]);
      chk($sformatf("lw_c%0d_adrsrc", c + 1), bus.adrsrc, adr_seq[c]);
      chk($sformatf("lw_c%0d_regwrite", c + 1), bus.regwrite, rw_seq[c]);
      if (c == 6) chk("lw_c7_resultsrc", bus.resultsrc, 1);
      tick();
    end
    chk("lw_retired", bus.retired, 2);
    @(negedge clk);
    chk("lw_back_fetch", bus.mem_req, 1);

    // illegal opcode: trap held 100 cycles, then asynchronous reset
    do_reset();
    bus.instr = 32'h0000007F;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!bus.illegal || bus.mem_req || bus.regwrite || bus.pc_we || bus.ir_we || bus.mem_we)
        bad++;
      tick();
    end
    chk("trap_hold_bad_cycles", bad, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("trap_rst_illegal", bus.illegal, 0);
    chk("trap_rst_mem_req", bus.mem_req, 0);
    chk("trap_rst_alusrc_b", bus.alusrc_b, 2);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("trap_rst_fetch", bus.mem_req, 1);
    tick();

    // reset in the middle of a store
    do_reset();
    bus.instr = 32'h0030A223;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    bus.mem_ready = 1'b0;
    tick();
    @(negedge clk);
    chk("sw_wait_mem_we", bus.mem_we, 1);
    #1 rst = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    chk("sw_rst_mem_we", bus.mem_we, 0);
    chk("sw_rst_mem_req", bus.mem_req, 0);
    chk("sw_rst_pc_we", bus.pc_we, 0);
    chk("sw_rst_ir_we", bus.ir_we, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("sw_restart_mem_req", bus.mem_req, 1);
    chk("sw_restart_mem_we", bus.mem_we, 0);
    chk("sw_restart_ir_we", bus.ir_we, 1);
    chk("sw_restart_retired", bus.retired, 0);
    tick();

    // retired wrap on the 4-bit instance: 17 adds
    rst2 = 1'b0;
    repeat (60) tick();
    chk("wrap_15", bus2.retired, 15);
    repeat (4) tick();
    chk("wrap_16", bus2.retired, 0);
    repeat (4) tick();
    chk("wrap_17", bus2.retired, 1);

    chk("no_memreq_rw_pcwe", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
